// File: rtl/clkdiv_pkg.sv
// Shared constants and ratio helpers for the multi-channel clock divider.
// Helpers operate on a 32-bit carrier; callers size-cast to their counter width.
package clkdiv_pkg;

    localparam int MIN_DIV   = 2;
    localparam int CNT_W_DEF = 16;
    localparam int HLP_W     = 32;

    // Ratios below the minimum cannot produce a period, so they are raised to it.
    function automatic logic [HLP_W-1:0] clamp_div(input logic [HLP_W-1:0] d);
        logic [HLP_W-1:0] r;
        if (d < HLP_W'(MIN_DIV)) begin
            r = HLP_W'(MIN_DIV);
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Number of high cycles in one period: floor(D/2).
    function automatic logic [HLP_W-1:0] half_div(input logic [HLP_W-1:0] d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending ratio and registered clk_out/tick/busy.
// Ratio changes only land on a period boundary, or immediately while parked.
module clk_div_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_act_div;
    logic [CNT_W-1:0] r_pend_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend_v;
    logic             r_clk_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_clamp;
    logic [CNT_W-1:0] w_act_nxt;
    logic [CNT_W-1:0] w_pend_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_half;
    logic             w_pend_v_nxt;
    logic             w_wrap;
    logic             w_tick_nxt;
    logic             w_clk_nxt;

    assign w_clamp = CNT_W'(clamp_div(HLP_W'(div_in)));

    // Next-state decode for ratio, pending flag, counter and both outputs.
    always_comb begin
        w_act_nxt    = r_act_div;
        w_pend_nxt   = r_pend_div;
        w_pend_v_nxt = r_pend_v;
        w_cnt_nxt    = r_cnt;
        w_tick_nxt   = 1'b0;
        w_wrap       = 1'b0;
        if (!en) begin
            // Parked: a fresh load wins over any older pending ratio.
            if (div_load) begin
                w_act_nxt    = w_clamp;
                w_pend_nxt   = w_clamp;
                w_pend_v_nxt = 1'b0;
            end else if (r_pend_v) begin
                w_act_nxt    = r_pend_div;
                w_pend_v_nxt = 1'b0;
            end else begin
                w_act_nxt    = r_act_div;
            end
            // Parking at the last count makes the first enabled edge a wrap.
            w_cnt_nxt = w_act_nxt - ONE;
        end else begin
            w_wrap = (r_cnt == (r_act_div - ONE)) || sync;
            if (w_wrap) begin
                w_cnt_nxt  = ZERO;
                w_tick_nxt = 1'b1;
                if (r_pend_v) begin
                    w_act_nxt    = r_pend_div;
                    w_pend_v_nxt = 1'b0;
                end else begin
                    w_act_nxt    = r_act_div;
                end
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
            // Applied after the wrap so a load on a boundary waits for the next one.
            if (div_load) begin
                w_pend_nxt   = w_clamp;
                w_pend_v_nxt = 1'b1;
            end else begin
                w_pend_nxt   = w_pend_nxt;
            end
        end
        w_half    = CNT_W'(half_div(HLP_W'(w_act_nxt)));
        w_clk_nxt = en && (w_cnt_nxt < w_half);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_act_div  <= DEF_DIV;
            r_pend_div <= DEF_DIV;
            r_pend_v   <= 1'b0;
            r_cnt      <= DEF_DIV - ONE;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_act_div  <= w_act_nxt;
            r_pend_div <= w_pend_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clk_out  <= w_clk_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign busy    = r_pend_v;

endmodule

// File: rtl/clk_divider_mc.sv
// Multi-channel runtime-programmable clock/enable generator.
// Each channel divides clk_in independently; sync restarts all enabled channels together.
module clk_divider_mc
    import clkdiv_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH*CNT_W-1:0] div_in,
    input  logic [N_CH-1:0]       div_load,
    input  logic                  sync,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       busy
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .en       (en[g]),
            .div_in   (div_in[g*CNT_W +: CNT_W]),
            .div_load (div_load[g]),
            .sync     (sync),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .busy     (busy[g])
        );
    end

endmodule

// File: tb/tb_clk_divider_mc.sv
// Directed bench for clk_divider_mc; outputs sampled on the falling edge.
module tb_clk_divider_mc;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic                  clk_in = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       en;
    logic [N_CH*CNT_W-1:0] div_in;
    logic [N_CH-1:0]       div_load;
    logic                  sync;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    clk_divider_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) u_dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected clk_out / tick for a channel of ratio d, k edges after its period start.
    function automatic logic exp_clk(input int d, input int k);
        return (k % d) < (d / 2);
    endfunction

    function automatic logic exp_tick(input int d, input int k);
        return (k % d) == 0;
    endfunction

    task automatic chk_ch(input string tag, input int ch, input int d, input int k);
        chk({tag, "_clk"}, 32'(clk_out[ch]), 32'(exp_clk(d, k)));
        chk({tag, "_tick"}, 32'(tick[ch]), 32'(exp_tick(d, k)));
    endtask

    task automatic nedge();
        @(negedge clk_in);
    endtask

    task automatic set_div(input int ch, input int d);
        div_in[ch*CNT_W +: CNT_W] = CNT_W'(d);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = '0;
        div_load = '0;
        sync     = 1'b0;
        nedge();
        chk("rst_clk", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        div_in = '0;
        do_reset();

        // Channel 1 loaded with 5 while parked, then all channels enabled.
        set_div(1, 5);
        div_load = 4'b0010;
        nedge();
        div_load = 4'b0000;
        chk("park_load_busy", 32'(busy), 32'd0);
        chk("park_clk", 32'(clk_out), 32'd0);
        en = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            nedge();
            chk_ch("d4_ch0", 0, 4, i);
            chk_ch("d5_ch1", 1, 5, i);
            chk_ch("d4_ch2", 2, 4, i);
            chk_ch("d4_ch3", 3, 4, i);
            if (i == 0) chk("run_busy", 32'(busy), 32'd0);
        end

        // Channel 0: change 4 -> 6 mid-period; takes effect at the next wrap.
        do_reset();
        en = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            nedge();
            if (i < 4) chk_ch("chg_old", 0, 4, i);
            else       chk_ch("chg_new", 0, 6, i - 4);
            chk("chg_busy", 32'(busy[0]), 32'((i == 2) || (i == 3)));
            if (i == 1) begin
                set_div(0, 6);
                div_load = 4'b0001;
            end
            if (i == 2) div_load = 4'b0000;
        end

        // Channel 2: loads of 0 then 1 within one period clamp to 2.
        do_reset();
        en = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            nedge();
            if (i < 4) chk_ch("clamp_old", 2, 4, i);
            else       chk_ch("clamp_new", 2, 2, i - 4);
            chk("clamp_busy", 32'(busy[2]), 32'((i >= 1) && (i <= 3)));
            if (i == 0) begin
                set_div(2, 0);
                div_load = 4'b0100;
            end
            if (i == 1) set_div(2, 1);
            if (i == 2) div_load = 4'b0000;
        end

        // Channels 0 (D=4) and 1 (D=6): sync mid-period, then sync on a shared wrap.
        do_reset();
        set_div(1, 6);
        div_load = 4'b0010;
        nedge();
        div_load = 4'b0000;
        en = 4'b0011;
        for (int i = 0; i < 41; i++) begin
            nedge();
            chk_ch("sync_ch0", 0, 4, (i < 7) ? i : i - 7);
            chk_ch("sync_ch1", 1, 6, (i < 7) ? i : i - 7);
            chk("sync_dis", 32'({clk_out[2], tick[2]}), 32'd0);
            if (i == 6 || i == 30) sync = 1'b1;
            if (i == 7 || i == 31) sync = 1'b0;
        end

        // Reset while a ratio is pending on channel 0.
        set_div(0, 6);
        div_load = 4'b0001;
        nedge();
        div_load = 4'b0000;
        chk("pend_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        nedge();
        chk("midrst_clk", 32'(clk_out), 32'd0);
        chk("midrst_tick", 32'(tick), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nedge();
            chk_ch("post_rst_ch0", 0, 4, i);
            chk_ch("post_rst_ch1", 1, 4, i);
        end

        // Load on a wrap edge, then drop en: parks cleanly and applies the ratio.
        set_div(0, 6);
        div_load = 4'b0001;
        nedge();
        div_load = 4'b0000;
        chk("wrapld_tick", 32'(tick[0]), 32'd1);
        chk("wrapld_clk", 32'(clk_out[0]), 32'd1);
        chk("wrapld_busy", 32'(busy[0]), 32'd1);
        en[0] = 1'b0;
        nedge();
        chk("enfall_out", 32'({clk_out[0], tick[0]}), 32'd0);
        chk("enfall_busy", 32'(busy[0]), 32'd0);
        en[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nedge();
            chk_ch("reen_d6", 0, 6, i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_divider_mc.md
Name: clk_divider_mc

Overview:
- Multi-channel, runtime-programmable clock/enable generator. Next generation of the fixed-ratio divider.
- Each of N_CH channels divides clk_in by its own integer ratio D, loaded at runtime. Any D ≥ 2 is legal, odd or even.
- Each channel outputs a square clk_out and a single-cycle tick (clock-enable) at each period start.
- Ratio changes are glitch-free and take effect only at a period boundary. A global sync pulse phase-aligns all enabled channels.
- Feeds the servo PWM, sensor-sampling and UART baud timing blocks from the 100 MHz system clock.

Parameters:
- N_CH, 4, number of independent divider channels (≥1).
- CNT_W, 16, width of each channel's ratio and counter (≥2).
- DEFAULT_DIV, 4, ratio loaded into every channel at reset (2 ≤ DEFAULT_DIV ≤ 2^CNT_W−1).

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  N_CH  per-channel run enable.
- div_in  in  N_CH*CNT_W  packed ratios; channel i uses bits [i*CNT_W +: CNT_W].
- div_load  in  N_CH  per-channel strobe; captures that channel's div_in slice.
- sync  in  1  single-cycle pulse; forces a period restart on all enabled channels.
- clk_out  out  N_CH  divided clock per channel, registered.
- tick  out  N_CH  one-cycle pulse coincident with each clk_out rising edge, registered.
- busy  out  N_CH  a captured ratio is pending and not yet applied.

Behaviour:
- Per-channel state:
  - act_div: active ratio.
  - pend_div: captured ratio.
  - pend_v: pending flag.
  - cnt: counter.
- Ratio clamp: a captured value of 0 or 1 is stored as 2. No other translation is applied.
- Reset (rst_n=0 at an edge), also mid-operation:
  - act_div = pend_div = DEFAULT_DIV; pend_v = 0; cnt = DEFAULT_DIV−1.
  - clk_out = 0, tick = 0, busy = 0, on all channels.
- Disabled channel (en[i]=0):
  - cnt is held at act_div−1; clk_out = 0, tick = 0.
  - A div_load updates act_div directly and clears pend_v. No pending state is kept.
- Enabled channel, every edge:
  - wrap = (cnt == act_div−1) OR sync.
  - On wrap: cnt←0, tick←1. If pend_v, act_div←pend_div and pend_v←0.
  - Otherwise: cnt←cnt+1, tick←0.
  - clk_out←(next_cnt < H), where H = next_act_div>>1. High for floor(D/2) cycles, low for ceil(D/2); exactly 50% duty for even D.
  - Because a disabled channel parks at act_div−1, the first enabled edge produces tick=1 and clk_out=1. Latency from en rising to first tick is 1 cycle.
- div_load on an enabled channel: pend_div←clamped slice, pend_v←1. Several loads before a boundary: the last one wins.
- busy[i] = pend_v[i], registered.
- Simultaneous events:
  - div_load on a wrap edge: the wrap applies the previously pending value (if any); the new value becomes pending for the next boundary.
  - sync on a wrap edge: a single wrap, no double tick.
  - sync with div_load: same rule as div_load with wrap.
  - en falling mid-period: the next edge parks the channel (clk_out=0, tick=0) with no truncated-high glitch beyond that edge. A pending ratio is applied immediately.
- sync is ignored by disabled channels.
- Counter never exceeds act_div−1. No overflow is possible since act_div ≤ 2^CNT_W−1.

Decomposition:
- Shared package clkdiv_pkg:
  - MIN_DIV = 2.
  - Default CNT_W.
  - Function clamp_div and the half-period (H) helper.
- Sub-module clk_div_chan: one channel (counter, active/pending ratio, clk_out/tick/busy). Parameterised by CNT_W and DEFAULT_DIV.
- Top level: generate-loop over N_CH instances of clk_div_chan, slicing div_in. sync is broadcast to all instances.

Test Plan:
- Reset, then en=1 on all channels with DEFAULT_DIV=4 → clk_out per channel = 1,1,0,0 repeating; tick on cycles 1, 5, 9; busy=0.
- Channel 1: load D=5 while disabled, then enable → clk_out = 1,1,0,0,0 repeating; tick every 5 cycles. Channel 0 remains at period 4.
- Channel 0 running D=4: load D=6 at cnt=1 → busy=1 until the next wrap; the remainder of the current period is unchanged. Subsequent periods are 6 cycles with 3 high / 3 low, and busy returns to 0.
- Load D=0, then D=1, on enabled channel 2 within one period → last value wins, clamped to 2: clk_out toggles every cycle with tick every 2 cycles.
- Channels with D=4 and D=6 drifting: assert sync at an arbitrary cycle → both tick on the next edge, then realign every 12 cycles. A sync landing on a natural wrap produces one tick only.
- Drive rst_n=0 mid-period with a ratio pending → next edge: all outputs 0, busy=0. After release, the channel runs at DEFAULT_DIV.
